store_buffer: RTL

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : Word-granular store buffer with same-word store merging,
//               per-byte load forwarding and FIFO drain to data memory.
// Revision    : 1.0
// ============================================================================
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic        FenceM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  count
);

    localparam int         c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] c_FULL  = 4'(DEPTH);

    logic [DEPTH-1:0]   r_valid;
    logic [29:0]        r_addr [DEPTH];
    logic [31:0]        r_data [DEPTH];
    logic [3:0]         r_be   [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [3:0]         r_count;

    logic               w_is_byte;
    logic               w_is_half;
    logic               w_mis_raw;
    logic [3:0]         w_st_be;
    logic [31:0]        w_st_data;
    logic [31:0]        w_lane_mask;
    logic [31:0]        w_merged;
    logic               w_nonempty;
    logic               w_full;
    logic               w_pop;
    logic [c_PTR_W-1:0] w_young;
    logic               w_merge;
    logic               w_stall;
    logic               w_accept;
    logic               w_do_merge;
    logic               w_do_push;
    logic [c_PTR_W-1:0] w_idx;
    logic [31:0]        w_fwd_word;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_ext;

    // Access decode and store lane placement
    always_comb begin
        w_is_byte = (funct3M[1:0] == 2'b00);
        w_is_half = (funct3M[1:0] == 2'b01);
        w_mis_raw = 1'b0;
        w_st_be   = 4'b1111;
        w_st_data = WriteDataM;
        if (w_is_byte) begin
            w_st_be   = 4'b0001 << ALUResultM[1:0];
            w_st_data = {4{WriteDataM[7:0]}};
        end else if (w_is_half) begin
            w_mis_raw = ALUResultM[0];
            w_st_be   = ALUResultM[1] ? 4'b1100 : 4'b0011;
            w_st_data = {2{WriteDataM[15:0]}};
        end else begin
            w_mis_raw = (ALUResultM[1:0] != 2'b00);
        end
    end

    assign w_lane_mask = {{8{w_st_be[3]}}, {8{w_st_be[2]}}, {8{w_st_be[1]}}, {8{w_st_be[0]}}};
    assign w_merged    = (r_data[w_young] & ~w_lane_mask) | (w_st_data & w_lane_mask);

    assign w_nonempty = (r_count != 4'd0);
    assign w_full     = (r_count == c_FULL);
    assign w_pop      = w_nonempty & mem_ready;
    assign w_young    = r_tail - c_PTR_W'(1);

    // The youngest entry cannot absorb a store while it is leaving the buffer
    assign w_merge = MemWriteM & ~w_mis_raw & w_nonempty & r_valid[w_young]
                   & (r_addr[w_young] == ALUResultM[31:2])
                   & ~(w_pop & (r_count == 4'd1));

    assign w_stall    = (MemWriteM & w_full & ~w_pop & ~w_merge) | (FenceM & w_nonempty);
    assign w_accept   = reset & MemWriteM & ~w_mis_raw & ~w_stall;
    assign w_do_merge = w_accept & w_merge;
    assign w_do_push  = w_accept & ~w_merge;

    assign StallM    = reset & w_stall;
    assign MisalignM = reset & (MemWriteM | MemReadM) & w_mis_raw;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + c_PTR_W'(1);
            end
            // When full, tail equals head: the push refills the slot just popped
            if (w_do_push) begin
                r_valid[r_tail] <= 1'b1;
                r_addr[r_tail]  <= ALUResultM[31:2];
                r_data[r_tail]  <= w_st_data;
                r_be[r_tail]    <= w_st_be;
                r_tail          <= r_tail + c_PTR_W'(1);
            end
            if (w_do_merge) begin
                r_data[w_young] <= w_merged;
                r_be[w_young]   <= r_be[w_young] | w_st_be;
            end
            case ({w_do_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign mem_we    = w_nonempty;
    assign mem_addr  = w_nonempty ? {r_addr[r_head], 2'b00} : 32'd0;
    assign mem_wdata = w_nonempty ? r_data[r_head] : 32'd0;
    assign mem_be    = w_nonempty ? r_be[r_head] : 4'b0000;
    assign count     = r_count;

    // Walk oldest to youngest so later entries override earlier ones per lane
    always_comb begin
        w_fwd_word = mem_rdata;
        w_idx      = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + c_PTR_W'(i);
            for (int l = 0; l < 4; l++) begin
                if (r_valid[w_idx] && (r_addr[w_idx] == ALUResultM[31:2]) && r_be[w_idx][l]) begin
                    w_fwd_word[8*l +: 8] = r_data[w_idx][8*l +: 8];
                end
            end
        end
    end

    assign w_byte = 8'(w_fwd_word >> {ALUResultM[1:0], 3'b000});
    assign w_half = ALUResultM[1] ? w_fwd_word[31:16] : w_fwd_word[15:0];

    always_comb begin
        case (funct3M)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b010:  w_ext = w_fwd_word;
            3'b100:  w_ext = {24'd0, w_byte};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = 32'd0;
        endcase
    end

    assign ReadDataM = (reset & MemReadM & ~MemWriteM & ~w_mis_raw) ? w_ext : 32'd0;

endmodule
`default_nettype wire
